camara_sensor_emu: RTL and testbench

//  Synthesisable model of the camera sensor side of the parallel video interface (Vsync/Href/Pclk/8-bit data).

---
 rtl/camara_pkg.sv | 33 +++
 rtl/camara_pattern_gen.sv | 38 +++
 rtl/camara_sensor_emu.sv | 184 ++++++++++++++++++
 tb/tb_camara_sensor_emu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/camara_pkg.sv
// Shared types and constants for the camera sensor emulator and its pattern generator.
package camara_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } cam_pattern_e;

  localparam logic [7:0] CHECK_EVEN_BYTE = 8'hAA;
  localparam logic [7:0] CHECK_ODD_BYTE  = 8'h55;
  localparam logic [7:0] SOLID_BYTE      = 8'hFF;

  // Entry [0] is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][15:0] BAR_RGB565 = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    return BAR_RGB565[idx];
  endfunction

endpackage

// File: rtl/camara_pattern_gen.sv
// Combinational test-pattern byte source: maps pixel position and pattern code to one
// RGB565 byte (high byte first). The caller masks the result outside href.
module camara_pattern_gen
  import camara_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COL_W    = 11
) (
  input  cam_pattern_e     pattern_i,
  input  logic [COL_W-1:0] p_i,
  input  logic             b_i,
  input  logic             row_lsb_i,
  input  logic [7:0]       col_lsb_i,
  output logic [7:0]       byte_o
);

  localparam logic [COL_W+2:0] H_ACTIVE_W = (COL_W + 3)'(H_ACTIVE);

  logic [COL_W+2:0] scaled_s;
  logic [2:0]       bar_s;
  logic [15:0]      colour_s;

  // Pattern byte selection
  always_comb begin
    scaled_s = {p_i, 3'b000};
    bar_s    = 3'(scaled_s / H_ACTIVE_W);
    colour_s = bar_colour(bar_s);
    byte_o   = 8'h00;
    case (pattern_i)
      PAT_RAMP:    byte_o = col_lsb_i;
      PAT_BARS:    byte_o = b_i ? colour_s[7:0] : colour_s[15:8];
      PAT_CHECKER: byte_o = (p_i[0] ^ row_lsb_i) ? CHECK_ODD_BYTE : CHECK_EVEN_BYTE;
      PAT_SOLID:   byte_o = SOLID_BYTE;
      default:     byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/camara_sensor_emu.sv
// Camera sensor emulator: produces the Vsync/Href/Pclk/8-bit stream the capture block samples.
// All stream outputs are registered and only change on the pclk falling edge (byte tick).
module camara_sensor_emu
  import camara_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 288,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_rst_n,
  input  logic        pwdn,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic [15:0] frame_cnt
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W     = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 2;
  localparam int ROW_MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int ROW_MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int ROW_MAX   = (ROW_MAX_A > ROW_MAX_B) ? ROW_MAX_A : ROW_MAX_B;
  localparam int ROW_W     = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] HREF_END = COL_W'(2 * H_ACTIVE);

  cam_state_e       state_q, state_d;
  cam_pattern_e     pattern_q, pattern_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             pclk_q, pclk_d;
  logic             vsync_q, vsync_d;
  logic             href_q, href_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             tick_s;
  logic             href_s;
  logic [ROW_W-1:0] last_row_s;
  logic [COL_W-1:0] pix_s;
  logic [7:0]       pat_byte_s;

  assign pix_s = {1'b0, col_q[COL_W-1:1]};

  camara_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .COL_W    (COL_W)
  ) u_pattern_gen (
    .pattern_i (pattern_q),
    .p_i       (pix_s),
    .b_i       (col_q[0]),
    .row_lsb_i (row_q[0]),
    .col_lsb_i (8'(col_q)),
    .byte_o    (pat_byte_s)
  );

  // Number of lines in the current state, minus one
  always_comb begin
    last_row_s = {ROW_W{1'b0}};
    case (state_q)
      ST_VSYNC:  last_row_s = ROW_W'(VSYNC_LINES - 1);
      ST_VBACK:  last_row_s = ROW_W'(V_BACK - 1);
      ST_ACTIVE: last_row_s = ROW_W'(V_ACTIVE - 1);
      ST_VFRONT: last_row_s = ROW_W'(V_FRONT - 1);
      default:   last_row_s = {ROW_W{1'b0}};
    endcase
  end

  // Frame FSM, position counters, pclk divider and stream output next-state
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    col_d       = col_q;
    row_d       = row_q;
    pclk_d      = pclk_q;
    vsync_d     = vsync_q;
    href_d      = href_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;
    tick_s      = pclk_q && (state_q != ST_IDLE);
    href_s      = (state_q == ST_ACTIVE) && (col_q < HREF_END);

    if (!cam_rst_n || pwdn) begin
      // Sensor held off: drop any partial frame; only a sensor reset clears the frame count.
      state_d = ST_IDLE;
      col_d   = {COL_W{1'b0}};
      row_d   = {ROW_W{1'b0}};
      pclk_d  = 1'b0;
      vsync_d = 1'b0;
      href_d  = 1'b0;
      data_d  = 8'h00;
      if (!cam_rst_n) begin
        frame_cnt_d = 16'h0000;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else if (state_q == ST_IDLE) begin
      col_d  = {COL_W{1'b0}};
      row_d  = {ROW_W{1'b0}};
      pclk_d = 1'b0;
      if (enable) begin
        state_d   = ST_VSYNC;
        pattern_d = cam_pattern_e'(pattern);
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      pclk_d = ~pclk_q;
      if (tick_s) begin
        vsync_d = (state_q == ST_VSYNC);
        href_d  = href_s;
        data_d  = href_s ? pat_byte_s : 8'h00;
        if (col_q == LAST_COL) begin
          col_d = {COL_W{1'b0}};
          if (row_q == last_row_s) begin
            row_d = {ROW_W{1'b0}};
            case (state_q)
              ST_VSYNC:  state_d = ST_VBACK;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: state_d = ST_VFRONT;
              ST_VFRONT: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                if (enable) begin
                  state_d   = ST_VSYNC;
                  pattern_d = cam_pattern_e'(pattern);
                end else begin
                  state_d = ST_IDLE;
                end
              end
              default:   state_d = ST_IDLE;
            endcase
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end else begin
        col_d = col_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pattern_q   <= PAT_RAMP;
      col_q       <= {COL_W{1'b0}};
      row_q       <= {ROW_W{1'b0}};
      pclk_q      <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pclk_q      <= pclk_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pclk      = pclk_q;
  assign vsync     = vsync_q;
  assign href      = href_q;
  assign data      = data_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_camara_sensor_emu.sv
// Directed bench for camara_sensor_emu: small-frame build (LINE_LEN=12) plus an H_ACTIVE=8
// build for the colour bars. Stream samples are taken while pclk is high.
module tb_camara_sensor_emu;

  logic        clk = 1'b0;
  logic        rst, cam_rst_n, pwdn, enable;
  logic [1:0]  pattern;
  logic        pclk, vsync, href;
  logic [7:0]  data;
  logic [15:0] frame_cnt;

  logic        en8;
  logic [1:0]  pattern8;
  logic        pclk8, vsync8, href8;
  logic [7:0]  data8;
  logic [15:0] frame_cnt8;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  camara_sensor_emu #(
    .H_ACTIVE(4), .H_BLANK(4), .V_ACTIVE(2), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) u_dut (
    .clk(clk), .rst(rst), .cam_rst_n(cam_rst_n), .pwdn(pwdn), .enable(enable),
    .pattern(pattern), .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .frame_cnt(frame_cnt)
  );

  camara_sensor_emu #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) u_dut8 (
    .clk(clk), .rst(rst), .cam_rst_n(cam_rst_n), .pwdn(pwdn), .enable(en8),
    .pattern(pattern8), .pclk(pclk8), .vsync(vsync8), .href(href8), .data(data8),
    .frame_cnt(frame_cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Wait (bounded) for the next clk cycle with pclk high and return {vsync, href, data}.
  task automatic get_sample(output logic [9:0] smp);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pclk === 1'b1) break;
    end
    if (pclk !== 1'b1) chk("pclk_timeout", 32'(pclk), 32'd1);
    smp = {vsync, href, data};
  endtask

  // Expected {vsync, href, data} at byte position pos (0..59) of a small frame.
  function automatic logic [9:0] exp_smp(input int pat, input int pos);
    int line, col;
    logic h;
    logic [7:0] d;
    line = pos / 12;
    col  = pos % 12;
    h    = ((line == 2) || (line == 3)) && (col < 8);
    d    = 8'h00;
    if (h) begin
      case (pat)
        0:       d = col[7:0];
        2:       d = ((((col / 2) ^ (line - 2)) & 1) != 0) ? 8'h55 : 8'hAA;
        3:       d = 8'hFF;
        default: d = 8'h00;
      endcase
    end
    return {(line == 0), h, d};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] smp;
    int         pats [3];
    int         t0, g, nhigh, nb;
    logic [7:0] got [16];
    logic [7:0] exp_bar [16];
    pats    = '{0, 3, 2};
    exp_bar = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    t0 = 0;

    rst = 1'b0; cam_rst_n = 1'b1; pwdn = 1'b0; enable = 1'b0; pattern = 2'd0;
    en8 = 1'b0; pattern8 = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pclk", 32'(pclk), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_href", 32'(href), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    rst = 1'b1;
    nhigh = 0;
    repeat (10) begin
      @(negedge clk);
      if (pclk !== 1'b0 || vsync !== 1'b0) nhigh++;
    end
    chk("idle_quiet", nhigh, 32'd0);

    // Three back-to-back frames: ramp, then solid and checker picked up at frame boundaries.
    enable = 1'b1;
    for (int s = 0; s < 180; s++) begin
      get_sample(smp);
      if (s == 0) begin
        chk("lead_idle", 32'(smp), 32'd0);
      end else begin
        g = s - 1;
        chk("frame_stream", 32'(smp), 32'(exp_smp(pats[g / 60], g % 60)));
      end
      if (s == 1) begin
        t0 = cyc;
        pattern = 2'd3;
      end
      if (s == 61) begin
        chk("frame_period", cyc - t0, 32'd120);
        chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
        pattern = 2'd2;
      end
      if (s == 121) chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
      if (s == 147) enable = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("disable_cnt", 32'(frame_cnt), 32'd3);
    nhigh = 0;
    repeat (20) begin
      @(negedge clk);
      if (pclk !== 1'b0) nhigh++;
    end
    chk("disable_pclk_low", nhigh, 32'd0);

    // Power-down in the middle of href.
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (href === 1'b1) break;
    end
    chk("href_seen", 32'(href), 32'd1);
    pwdn = 1'b1;
    @(negedge clk);
    chk("pwdn_href", 32'(href), 32'd0);
    chk("pwdn_data", 32'(data), 32'd0);
    chk("pwdn_pclk", 32'(pclk), 32'd0);
    chk("pwdn_vsync", 32'(vsync), 32'd0);
    chk("pwdn_cnt", 32'(frame_cnt), 32'd3);
    repeat (5) @(negedge clk);
    chk("pwdn_hold_pclk", 32'(pclk), 32'd0);
    pwdn = 1'b0;
    get_sample(smp);
    chk("restart_lead", 32'(smp), 32'd0);
    get_sample(smp);
    chk("restart_vsync", 32'(smp), 32'h200);
    chk("restart_cnt", 32'(frame_cnt), 32'd3);
    enable = 1'b0;
    repeat (160) @(negedge clk);
    chk("restart_frame_cnt", 32'(frame_cnt), 32'd4);

    cam_rst_n = 1'b0;
    @(negedge clk);
    chk("camrst_cnt", 32'(frame_cnt), 32'd0);
    chk("camrst_pclk", 32'(pclk), 32'd0);
    cam_rst_n = 1'b1;

    // Frame counter wrap from a preset of 0xFFFF.
    @(negedge clk);
    force u_dut.frame_cnt_d = 16'hFFFF;
    @(negedge clk);
    release u_dut.frame_cnt_d;
    @(negedge clk);
    chk("preset_cnt", 32'(frame_cnt), 32'h0000FFFF);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (160) @(negedge clk);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    // Colour bars on the H_ACTIVE=8 build: first active line.
    en8 = 1'b1;
    pattern8 = 2'd1;
    nb = 0;
    for (int i = 0; i < 400 && nb < 16; i++) begin
      @(negedge clk);
      if (pclk8 === 1'b1 && href8 === 1'b1) begin
        got[nb] = data8;
        nb++;
      end
    end
    en8 = 1'b0;
    chk("bar_count", nb, 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (k < nb) chk("bar_byte", 32'(got[k]), 32'(exp_bar[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
